// File: rtl/io_seg_scheduler.sv
// Queues CPU-written seven-segment words and shows each one for a fixed dwell time.
// Optional macro IO_SEG_DWELL_PROG_EN adds a runtime-programmable dwell register.
module io_seg_scheduler #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 24,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              flush,
    input  logic              hold,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
`ifdef IO_SEG_DWELL_PROG_EN
    input  logic              dwell_wr,
    input  logic [31:0]       dwell_in,
`endif
    output logic              overflow
);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    localparam logic [ADDR_W:0] C_DEPTH      = (ADDR_W+1)'(DEPTH);
    localparam logic [31:0]     C_DWELL      = 32'(DWELL_CYCLES);
    localparam logic [31:0]     C_DWELL_LOAD = 32'(DWELL_CYCLES - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_timer;
    logic [DATA_W-1:0] r_dispData;
    logic              r_dispValid;
    logic              r_overflow;
    state_t            r_state;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_loadVal;

`ifdef IO_SEG_DWELL_PROG_EN
    logic [31:0] r_dwell;

    // Survives flush so a programmed rate is not lost when the queue is cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dwell <= C_DWELL;
        end else if (dwell_wr) begin
            r_dwell <= (dwell_in == 32'd0) ? 32'd1 : dwell_in;
        end
    end

    assign w_loadVal = r_dwell - 32'd1;
`else
    assign w_loadVal = C_DWELL_LOAD;
`endif

    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign full     = w_full;
    assign empty    = w_empty;
    assign wr_ready = !w_full;
    assign count    = r_count;
    assign disp_data  = r_dispData;
    assign disp_valid = r_dispValid;
    assign overflow   = r_overflow;

    // Fullness is judged before the edge, so a same-edge pop never frees a slot for a write.
    assign w_push = rst_n && !flush && wr_valid && !w_full;
    assign w_pop  = rst_n && !flush && !w_empty &&
                    ((r_state == S_IDLE) || (!hold && (r_timer == 32'd0)));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_dispData  <= '0;
            r_dispValid <= 1'b0;
            r_overflow  <= 1'b0;
            r_state     <= S_IDLE;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            if (wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_dispData  <= r_mem[r_rdPtr];
                        r_dispValid <= 1'b1;
                        r_timer     <= w_loadVal;
                        r_state     <= S_SHOW;
                    end else begin
                        r_dispData  <= '0;
                        r_dispValid <= 1'b0;
                    end
                end
                S_SHOW: begin
                    if (!hold) begin
                        if (r_timer != 32'd0) begin
                            r_timer <= r_timer - 32'd1;
                        end else if (w_pop) begin
                            r_dispData <= r_mem[r_rdPtr];
                            r_timer    <= w_loadVal;
                        end else begin
                            r_dispData  <= '0;
                            r_dispValid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/io_seg_scheduler.md
Name: io_seg_scheduler

Overview:
- Sequences 24-bit seven-segment display words written by the CPU through the IO segment address.
- Each queued word is shown for a fixed dwell time, then the next word is shown.
- Sits between the IO write decode (data from Read_data_2[23:0], strobed on a segment-address write) and the segment driver (IO_seg_out).
- Replaces ad-hoc queue pointers with a bounded FIFO, an explicit FSM, flow control, flush/hold controls and overflow reporting.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- DATA_W, 24, width of one display word.
- DWELL_CYCLES, 100000000, clk cycles each word is displayed; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr_valid  input  1  CPU write strobe: IOWrite qualified with the segment address.
- wr_data  input  DATA_W  word to enqueue.
- wr_ready  output  1  high when the FIFO can accept a word; equals !full.
- flush  input  1  synchronous clear of queue and display.
- hold  input  1  freezes the dwell timer while high.
- disp_data  output  DATA_W  word to drive IO_seg_out.
- disp_valid  output  1  high while disp_data holds a displayed word.
- count  output  ADDR_W+1  number of queued words, not including the word being displayed.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a write was attempted while full.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - wr/rd pointers=0, count=0, timer=0, FSM=IDLE.
  - disp_data=0, disp_valid=0, overflow=0.
  - full=0, empty=1, wr_ready=1.
  - Reset mid-display abandons the current word immediately. FIFO RAM contents are don't-care.
- Push: on an edge with wr_valid && !full && !flush, write wr_data at wr_ptr and increment wr_ptr modulo DEPTH.
- Push refused: on an edge with wr_valid && full && !flush, drop the word and set overflow=1. A pop on the same edge does not make room; wr_ready is evaluated from the pre-edge state.
- Pointers wrap from DEPTH-1 to 0 naturally via ADDR_W-bit arithmetic. count updates by +1, -1, or 0 when push and pop occur on the same edge.
- FSM IDLE:
  - If !empty: pop the head into disp_data, set disp_valid=1, load timer=DWELL_CYCLES-1, go to SHOW.
  - Else: disp_data=0, disp_valid=0.
- FSM SHOW:
  - If hold: the timer holds its value and nothing else changes.
  - Else if timer!=0: decrement the timer.
  - Else if !empty: pop the next word into disp_data, reload timer=DWELL_CYCLES-1, stay in SHOW. Back-to-back words have no blank cycle.
  - Else: disp_data=0, disp_valid=0, go to IDLE.
- Timing:
  - Each word is visible for exactly DWELL_CYCLES cycles with hold=0.
  - Hold extends the visible time by the number of held cycles.
  - Latency: a word accepted at edge E into an empty, IDLE scheduler has disp_valid=1 after edge E+1.
  - A word written into an empty FIFO on the same edge SHOW expires goes IDLE first and is then shown after the following edge, giving one blank cycle.
- flush (rst_n=1):
  - Same effect as reset on pointers, count, FSM, timer, disp_data, disp_valid and overflow.
  - Takes priority over a simultaneous write; that write is discarded and does not set overflow.
- hold does not block pushes, and it does not block the pop taken in IDLE.
- All outputs are registered except wr_ready, full and empty, which decode from count.

Optional Feature:
- Macro: IO_SEG_DWELL_PROG_EN.
- Defined:
  - Adds input ports dwell_wr (1) and dwell_in (32), plus a dwell register reset/flush-independent to DWELL_CYCLES.
  - dwell_wr at an edge loads dwell_in into the register; a value of 0 is stored as 1.
  - Every timer load uses register-1.
  - A change does not alter the word currently counting; it applies from the next load.
- Not defined: ports absent; every load uses DWELL_CYCLES-1.

Test Plan (DEPTH=4, DWELL_CYCLES=4):
- Reset, then one write of 0x123456 at edge 10 -> disp_valid=1 and disp_data=0x123456 after edge 11 through edge 14; after edge 15 disp_valid=0, disp_data=0, empty=1.
- Write 0xA, 0xB, 0xC on consecutive edges -> each word shown for exactly 4 cycles, no blank cycle between words, count reaches 2 then drains to 0.
- With display stalled (hold=1), write 5 words -> first word displayed; next 4 fill the FIFO (full=1, wr_ready=0); a 6th write sets overflow=1 and its data is never displayed.
- Hold high for 3 cycles mid-word -> that word is visible for 7 cycles; the next word follows with correct data.
- With 3 queued words and one displaying, assert flush alongside wr_valid=1 -> after the edge: count=0, empty=1, disp_valid=0, overflow=0, and the concurrent word is not queued.
- Fill, drain and refill across the DEPTH boundary 3 times -> output order matches input order and count is never negative and never exceeds 4. With IO_SEG_DWELL_PROG_EN, dwell_in=2 gives 2-cycle words and dwell_in=0 gives 1-cycle words.
